// File: rtl/vector_hazard_unit_if.sv
// Hazard-unit bundle: decode/execute/memory/writeback register addresses and
// control bits in, forwarding selects and pipe load enables out.
interface vector_hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       ra1D;
    logic [3:0]       ra2D;
    logic [3:0]       ra1E;
    logic [3:0]       ra2E;
    logic [3:0]       WA3E;
    logic             RegWriteE;
    logic             MemtoRegE;
    logic [3:0]       WA3M;
    logic             RegWriteM;
    logic [3:0]       WA3W;
    logic             RegWriteW;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             cargarF;
    logic             cargarD;
    logic             cargarE;
    logic             cargarM;
    logic             flushE;
    logic [CNT_W-1:0] stall_cycles;

    // Pipeline side: supplies addresses/control, consumes selects and enables.
    modport master (
        output ra1D, ra2D, ra1E, ra2E, WA3E, RegWriteE, MemtoRegE,
               WA3M, RegWriteM, WA3W, RegWriteW,
        input  ForwardAE, ForwardBE, cargarF, cargarD, cargarE, cargarM,
               flushE, stall_cycles
    );

    // Hazard unit side.
    modport slave (
        input  ra1D, ra2D, ra1E, ra2E, WA3E, RegWriteE, MemtoRegE,
               WA3M, RegWriteM, WA3W, RegWriteW,
        output ForwardAE, ForwardBE, cargarF, cargarD, cargarE, cargarM,
               flushE, stall_cycles
    );
endinterface

// File: rtl/vector_hazard_unit.sv
// Hazard unit for the 8-lane x 20-bit vector CPU: operand forwarding selects,
// load-use bubble, multi-cycle vector-load freeze and a saturating stall counter.
module vector_hazard_unit #(
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 16
) (
    input logic                 clk,
    input logic                 reset,
    vector_hazard_unit_if.slave hz
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    // Freeze length is MEM_LAT-1; the load itself spends its first memory
    // cycle advancing on the entry edge.
    localparam logic [3:0]       WAIT_INIT = 4'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam bit               HAS_WAIT  = (MEM_LAT > 1);

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic       loaduse_s;
    logic       cargar_f_s, cargar_d_s, cargar_e_s, cargar_m_s, flush_e_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    // Memory stage wins over writeback; register 0 is an ordinary register.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra,
        input logic [3:0] wa_m,
        input logic       we_m,
        input logic [3:0] wa_w,
        input logic       we_w
    );
        logic [1:0] sel;
        if (we_m && (wa_m == ra)) begin
            sel = 2'b10;
        end else if (we_w && (wa_w == ra)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign loaduse_s = hz.MemtoRegE && hz.RegWriteE &&
                       ((hz.WA3E == hz.ra1D) || (hz.WA3E == hz.ra2D));

    // Forwarding selects, evaluated in every state; forced to 00 in reset.
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        if (reset) begin
            fwd_a_s = fwd_sel(hz.ra1E, hz.WA3M, hz.RegWriteM, hz.WA3W, hz.RegWriteW);
            fwd_b_s = fwd_sel(hz.ra2E, hz.WA3M, hz.RegWriteM, hz.WA3W, hz.RegWriteW);
        end else begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end
    end

    // Pipe enables, flush and next FSM/counter state.
    always_comb begin
        cargar_f_s = 1'b1;
        cargar_d_s = 1'b1;
        cargar_e_s = 1'b1;
        cargar_m_s = 1'b1;
        flush_e_s  = 1'b0;
        state_d    = state_q;
        wait_d     = wait_q;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (loaduse_s) begin
                        cargar_f_s = 1'b0;
                        cargar_d_s = 1'b0;
                        flush_e_s  = 1'b1;
                    end else begin
                        flush_e_s  = 1'b0;
                    end
                    // The load enters the memory stage on this edge even if a
                    // bubble is injected behind it.
                    if (hz.MemtoRegE && HAS_WAIT) begin
                        state_d = MEMWAIT;
                        wait_d  = WAIT_INIT;
                    end else begin
                        state_d = IDLE;
                        wait_d  = 4'd0;
                    end
                end
                MEMWAIT: begin
                    cargar_f_s = 1'b0;
                    cargar_d_s = 1'b0;
                    cargar_e_s = 1'b0;
                    cargar_m_s = 1'b0;
                    if (wait_q == 4'd1) begin
                        state_d = IDLE;
                        wait_d  = 4'd0;
                    end else begin
                        wait_d  = wait_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    wait_d  = 4'd0;
                end
            endcase
        end else begin
            state_d = IDLE;
            wait_d  = 4'd0;
        end
    end

    // Saturating count of cycles in which fetch is held.
    always_comb begin
        if (!cargar_f_s && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // State, wait counter and stall counter with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign hz.ForwardAE    = fwd_a_s;
    assign hz.ForwardBE    = fwd_b_s;
    assign hz.cargarF      = cargar_f_s;
    assign hz.cargarD      = cargar_d_s;
    assign hz.cargarE      = cargar_e_s;
    assign hz.cargarM      = cargar_m_s;
    assign hz.flushE       = flush_e_s;
    assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_vector_hazard_unit.sv
// Bench for vector_hazard_unit: three instances (MEM_LAT/CNT_W = 3/16, 15/4,
// 1/16) share identical stimulus and are compared to a per-instance reference
// model that tracks remaining freeze cycles and stall count as plain integers.
module tb_vector_hazard_unit;

    logic clk;
    logic reset;
    logic [3:0] ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W;
    logic RegWriteE, MemtoRegE, RegWriteM, RegWriteW;

    int checks = 0;
    int errors = 0;

    vector_hazard_unit_if #(.CNT_W(16)) if0 ();
    vector_hazard_unit_if #(.CNT_W(4))  if1 ();
    vector_hazard_unit_if #(.CNT_W(16)) if2 ();

`define HZ_BIND(IFN) \
    assign IFN.ra1D = ra1D; assign IFN.ra2D = ra2D; \
    assign IFN.ra1E = ra1E; assign IFN.ra2E = ra2E; \
    assign IFN.WA3E = WA3E; assign IFN.RegWriteE = RegWriteE; \
    assign IFN.MemtoRegE = MemtoRegE; assign IFN.WA3M = WA3M; \
    assign IFN.RegWriteM = RegWriteM; assign IFN.WA3W = WA3W; \
    assign IFN.RegWriteW = RegWriteW;

    `HZ_BIND(if0)
    `HZ_BIND(if1)
    `HZ_BIND(if2)

    vector_hazard_unit #(.MEM_LAT(3),  .CNT_W(16)) dut0 (.clk(clk), .reset(reset), .hz(if0));
    vector_hazard_unit #(.MEM_LAT(15), .CNT_W(4))  dut1 (.clk(clk), .reset(reset), .hz(if1));
    vector_hazard_unit #(.MEM_LAT(1),  .CNT_W(16)) dut2 (.clk(clk), .reset(reset), .hz(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed outputs: {ForwardAE, ForwardBE, cargarF, cargarD, cargarE, cargarM, flushE, stall[15:0]}
    logic [24:0] act [3];
    logic [24:0] exp_v [3];
    assign act[0] = {if0.ForwardAE, if0.ForwardBE, if0.cargarF, if0.cargarD,
                     if0.cargarE, if0.cargarM, if0.flushE, if0.stall_cycles};
    assign act[1] = {if1.ForwardAE, if1.ForwardBE, if1.cargarF, if1.cargarD,
                     if1.cargarE, if1.cargarM, if1.flushE, 12'd0, if1.stall_cycles};
    assign act[2] = {if2.ForwardAE, if2.ForwardBE, if2.cargarF, if2.cargarD,
                     if2.cargarE, if2.cargarM, if2.flushE, if2.stall_cycles};

    localparam logic [8:0] CTL_RUN    = 9'b00_00_1111_0;
    localparam logic [8:0] CTL_BUBBLE = 9'b00_00_0011_1;
    localparam logic [8:0] CTL_FREEZE = 9'b00_00_0000_0;

    // Reference model state: freeze cycles still owed and stall count.
    int lat   [3] = '{3, 15, 1};
    int cmax  [3] = '{65535, 15, 65535};
    int frz   [3] = '{0, 0, 0};
    int stl   [3] = '{0, 0, 0};

    function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
        if (RegWriteM && WA3M == ra) return 2'b10;
        if (RegWriteW && WA3W == ra) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_loaduse();
        return MemtoRegE && RegWriteE && (WA3E == ra1D || WA3E == ra2D);
    endfunction

    // Let combinational outputs settle, then form expected outputs.
    task automatic settle();
        logic [3:0] en;
        logic       fl;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                exp_v[k] = {CTL_RUN, 16'(stl[k])};
            end else begin
                if (frz[k] > 0) begin
                    en = 4'b0000; fl = 1'b0;
                end else if (ref_loaduse()) begin
                    en = 4'b0011; fl = 1'b1;
                end else begin
                    en = 4'b1111; fl = 1'b0;
                end
                exp_v[k] = {ref_fwd(ra1E), ref_fwd(ra2E), en, fl, 16'(stl[k])};
            end
        end
    endtask

    // Advance one clock and update the model with the inputs held this cycle.
    task automatic tick();
        bit stalled;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                frz[k] = 0;
                stl[k] = 0;
            end else begin
                stalled = (frz[k] > 0) || ref_loaduse();
                if (stalled) stl[k] = (stl[k] >= cmax[k]) ? cmax[k] : stl[k] + 1;
                if (frz[k] > 0) frz[k] = frz[k] - 1;
                else if (MemtoRegE && lat[k] > 1) frz[k] = lat[k] - 1;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        {ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteE, MemtoRegE, RegWriteM, RegWriteW} = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        settle();
        checks++;
        if (act[0] !== {CTL_RUN, 16'd0}) begin
            $display("FAIL reset_held got %h exp %h", act[0], {CTL_RUN, 16'd0});
            errors++;
        end
        reset = 1'b1;
        settle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act[k] !== {CTL_RUN, 16'd0}) begin
                $display("FAIL reset_release inst%0d got %h exp %h", k, act[k], {CTL_RUN, 16'd0});
                errors++;
            end
        end
        tick();
    endtask

    task automatic test_forwarding();
        // {ra1E, ra2E, WA3M, RWM, WA3W, RWW, expA, expB}
        logic [21:0] tbl [6];
        tbl[0] = {4'd3, 4'd9, 4'd3, 1'b1, 4'd3, 1'b1, 2'b10, 2'b00};
        tbl[1] = {4'd3, 4'd9, 4'd3, 1'b0, 4'd3, 1'b1, 2'b01, 2'b00};
        tbl[2] = {4'd9, 4'd3, 4'd3, 1'b1, 4'd3, 1'b1, 2'b00, 2'b10};
        tbl[3] = {4'd9, 4'd3, 4'd3, 1'b0, 4'd3, 1'b1, 2'b00, 2'b01};
        tbl[4] = {4'd0, 4'd0, 4'd0, 1'b1, 4'd7, 1'b1, 2'b10, 2'b10};
        tbl[5] = {4'd3, 4'd3, 4'd3, 1'b0, 4'd3, 1'b0, 2'b00, 2'b00};
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            {ra1E, ra2E, WA3M, RegWriteM, WA3W, RegWriteW} = tbl[i][21:4];
            settle();
            checks++;
            if (act[0][24:21] !== tbl[i][3:0]) begin
                $display("FAIL fwd_row%0d got %b exp %b", i, act[0][24:21], tbl[i][3:0]);
                errors++;
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== exp_v[k]) begin
                    $display("FAIL fwd_model inst%0d row%0d got %h exp %h", k, i, act[k], exp_v[k]);
                    errors++;
                end
            end
            tick();
        end
    endtask

    // One vector load; hazard selects whether decode reads its destination.
    task automatic run_load(input bit hazard, input string name,
                            input logic [8:0] c0, input int stall_exp);
        logic [8:0] want [4];
        want = '{c0, CTL_FREEZE, CTL_FREEZE, CTL_RUN};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            if (c == 0) begin
                MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5;
                ra1D = 4'd6; ra2D = hazard ? 4'd5 : 4'd6;
            end
            settle();
            checks++;
            if (act[0][24:16] !== want[c]) begin
                $display("FAIL %s_ctl cyc%0d got %b exp %b", name, c, act[0][24:16], want[c]);
                errors++;
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== exp_v[k]) begin
                    $display("FAIL %s_model inst%0d cyc%0d got %h exp %h", name, k, c, act[k], exp_v[k]);
                    errors++;
                end
            end
            if (c == 3) begin
                checks++;
                if (act[0][15:0] !== 16'(stall_exp)) begin
                    $display("FAIL %s_stall got %0d exp %0d", name, act[0][15:0], stall_exp);
                    errors++;
                end
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        run_load(1'b1, "load_use", CTL_BUBBLE, 3);
    endtask

    task automatic test_load_nohazard();
        run_load(1'b0, "load_nohaz", CTL_RUN, 2);
    endtask

    task automatic test_reset_midwait();
        do_reset();
        clear_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; ra1D = 4'd6; ra2D = 4'd6;
        settle();
        tick();
        clear_inputs();
        reset = 1'b0;
        settle();
        tick();
        reset = 1'b1;
        settle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act[k] !== {CTL_RUN, 16'd0}) begin
                $display("FAIL midwait_release inst%0d got %h exp %h", k, act[k], {CTL_RUN, 16'd0});
                errors++;
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; ra1D = 4'd6; ra2D = 4'd6;
        for (int c = 0; c < 40; c++) begin
            settle();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== exp_v[k]) begin
                    $display("FAIL b2b_model inst%0d cyc%0d got %h exp %h", k, c, act[k], exp_v[k]);
                    errors++;
                end
            end
            if (c >= 35) begin
                checks++;
                if (act[1][3:0] !== 4'd15) begin
                    $display("FAIL b2b_saturate cyc%0d got %0d exp 15", c, act[1][3:0]);
                    errors++;
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 39) != 0);
            ra1D      = 4'($urandom_range(0, 3));
            ra2D      = 4'($urandom_range(0, 3));
            ra1E      = 4'($urandom_range(0, 3));
            ra2E      = 4'($urandom_range(0, 3));
            WA3E      = 4'($urandom_range(0, 3));
            WA3M      = 4'($urandom_range(0, 3));
            WA3W      = 4'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1));
            MemtoRegE = ($urandom_range(0, 3) == 0);
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            settle();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== exp_v[k]) begin
                    $display("FAIL rnd_model inst%0d cyc%0d got %h exp %h", k, c, act[k], exp_v[k]);
                    errors++;
                end
            end
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_load_nohazard();
        test_reset_midwait();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_hazard_unit.md
Name: vector_hazard_unit

Overview:
- Control-side counterpart of the decode/execute pipeline register in the 8-lane x 20-bit vector CPU.
- Consumes the register addresses and control bits the pipe registers emit, and returns forwarding selects to the execute stage.
- Produces the `cargar` load enables and the execute flush that drive the pipe registers.
- Handles load-use bubbles and multi-cycle vector-load freezes with a small FSM and counter, and keeps a stall-cycle performance counter.

Parameters:
- MEM_LAT, 3, cycles a vector load occupies the memory stage; legal range 1..15.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- ra1D  input  4  source register A of the instruction in decode
- ra2D  input  4  source register B of the instruction in decode
- ra1E  input  4  source register A in execute (decode-pipe ra1o)
- ra2E  input  4  source register B in execute (decode-pipe ra2o)
- WA3E  input  4  destination register in execute
- RegWriteE  input  1  execute-stage register write
- MemtoRegE  input  1  execute-stage instruction is a vector load
- WA3M  input  4  destination register in memory stage
- RegWriteM  input  1  memory-stage register write
- WA3W  input  4  destination register in writeback
- RegWriteW  input  1  writeback register write
- ForwardAE  output  2  operand A select: 00 register file, 10 memory-stage result, 01 writeback result
- ForwardBE  output  2  operand B select, same encoding as ForwardAE
- cargarF  output  1  fetch/PC load enable
- cargarD  output  1  fetch/decode pipe load enable
- cargarE  output  1  decode/execute pipe load enable
- cargarM  output  1  execute/memory pipe load enable
- flushE  output  1  clears the decode/execute pipe (bubble)
- stall_cycles  output  CNT_W  saturating count of cycles with cargarF=0

Behaviour:
- Only the state register, the wait counter and stall_cycles are registered. All other outputs are combinational, valid in the same cycle as their inputs.
- Reset:
  - On any clk edge with reset=0: state<=IDLE, wait counter<=0, stall_cycles<=0.
  - While reset=0: ForwardAE=ForwardBE=00, all cargar*=1, flushE=0.
  - Reset mid-MEMWAIT aborts the wait. The first cycle after reset is released is IDLE.
- Forwarding (both operands, all 16 addresses including register 0; no hardwired zero):
  - ForwardAE=10 if RegWriteM and WA3M==ra1E.
  - Else ForwardAE=01 if RegWriteW and WA3W==ra1E.
  - Else ForwardAE=00.
  - The memory stage has priority over writeback. ForwardBE is identical using ra2E.
  - Forwarding is evaluated in every state.
- Load-use hazard: loaduse = MemtoRegE and RegWriteE and (WA3E==ra1D or WA3E==ra2D).
- FSM states IDLE and MEMWAIT.
- IDLE:
  - If loaduse: cargarF=0, cargarD=0, flushE=1, cargarE=1, cargarM=1 (one bubble).
  - Otherwise all cargar*=1, flushE=0.
  - If MemtoRegE=1 and MEM_LAT>1: next state MEMWAIT, wait counter<=MEM_LAT-1. This applies regardless of loaduse, since the load advances into the memory stage on this edge.
- MEMWAIT:
  - All cargar*=0, flushE=0, loaduse ignored (whole front pipeline frozen).
  - Counter decrements each cycle. When counter==1, next state IDLE (counter<=0).
  - Freeze length is exactly MEM_LAT-1 cycles.
- Simultaneous load-use and MEMWAIT entry: the bubble is injected on the entry edge, then the freeze follows.
- MEM_LAT=1: MEMWAIT is never entered; a load costs only the load-use bubble, if any.
- stall_cycles increments on each edge where cargarF=0 and reset=1, and saturates at all-ones (no wrap).

Test Plan:
1. Reset low 2 cycles, then release with all inputs 0 -> ForwardAE/BE=00, cargarF/D/E/M=1, flushE=0, stall_cycles=0.
2. ra1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Same pattern on ra2E -> ForwardBE. With WA3M=0, ra1E=0 -> forwarding still asserted.
3. MEM_LAT=3; MemtoRegE=1, RegWriteE=1, WA3E=5, ra2D=5 for one cycle, then 0:
   - Cycle 0: cargarF=cargarD=0, flushE=1, cargarE=cargarM=1.
   - Cycles 1-2: all cargar*=0.
   - Cycle 3: all cargar*=1.
   - stall_cycles=3.
4. MEM_LAT=3; same load with WA3E=5, ra1D=ra2D=6 -> no flush in cycle 0; 2-cycle freeze; stall_cycles=2.
5. Load entering MEMWAIT, reset=0 during the first freeze cycle, then released -> IDLE with all cargar*=1 immediately after release, stall_cycles=0.
6. CNT_W=4, MEM_LAT=15; issue two back-to-back loads -> stall_cycles reaches 15 and holds at 15 (no wrap to 0).
